tff_seq_ctrl: RTL

Sequencing controller for a WIDTH-bit bank of T flip-flops built from D flip-flops (q <= q ^ t_vec). The block owns the bank and computes the per-bit toggle vector every cycle, so the bank behaves as a programmable up/down counter. Software controls it with start, stop, direction, mode and limit. It sits above the T-from-D flip-flop primitives and is the only agent that drives their T inputs.

---
 rtl/tff_seq_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/tff_seq_ctrl.sv
// tff_seq_ctrl: start/stop sequencer driving the toggle inputs of a T flip-flop bank
// so that the bank counts up or down, wrapping or one-shot, between 0 and a latched limit.
module tff_seq_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             dir,
   input  logic             mode,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] t_vec,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             tc,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [WIDTH-1:0] ONE = 1;
   state_t state_q, state_d;
   logic [WIDTH-1:0] q_q, lim_q, lim_d, init, term, load, nxt;
   logic dir_q, dir_d, mode_q, mode_d, tc_q, tc_d, done_q, done_d;
   always_comb begin
      init    = dir_q ? lim_q : '0;
      term    = dir_q ? '0 : lim_q;
      load    = dir ? limit : '0;
      nxt     = dir_q ? q_q - ONE : q_q + ONE;
      state_d = IDLE;
      t_vec   = '0;
      dir_d   = dir_q;
      mode_d  = mode_q;
      lim_d   = lim_q;
      tc_d    = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE, DONE: if (start && !stop) begin
            t_vec   = q_q ^ load;
            dir_d   = dir;
            mode_d  = mode;
            lim_d   = limit;
            state_d = RUN;
         end
         RUN: if (!stop) begin
            // xor with the neighbour value yields exactly the ripple-carry/borrow toggle pattern
            if (q_q == term) begin
               tc_d    = 1'b1;
               done_d  = mode_q;
               t_vec   = mode_q ? '0 : q_q ^ init;
               state_d = mode_q ? DONE : RUN;
            end else begin
               t_vec   = q_q ^ nxt;
               state_d = RUN;
            end
         end
         default: ;
      endcase
      if (rst) t_vec = '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         q_q     <= '0;
         dir_q   <= 1'b0;
         mode_q  <= 1'b0;
         lim_q   <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_q ^ t_vec;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         lim_q   <= lim_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end
   assign q    = q_q;
   assign busy = state_q == RUN;
   assign tc   = tc_q;
   assign done = done_q;
endmodule
